// File: rtl/alu_operand_stage_if.sv
// Handshake and datapath bundle between the decode side, the forwarding
// sources and the ALU operand stage.
interface alu_operand_stage_if #(
   parameter int WIDTH = 32,
   parameter int RA    = 5
);
   localparam int SW = $clog2(WIDTH);

   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [RA-1:0]    in_rs1_addr;
   logic [RA-1:0]    in_rs2_addr;
   logic [RA-1:0]    in_rd_addr;
   logic [WIDTH-1:0] in_rs1_data;
   logic [WIDTH-1:0] in_rs2_data;
   logic [WIDTH-1:0] in_imm;
   logic [WIDTH-1:0] in_pc;
   logic             in_use_imm;
   logic             in_use_pc;
   logic [4:0]       in_alu_control;
   logic             in_is_load;
   logic             mem_wr_en;
   logic [RA-1:0]    mem_rd_addr;
   logic [WIDTH-1:0] mem_data;
   logic             wb_wr_en;
   logic [RA-1:0]    wb_rd_addr;
   logic [WIDTH-1:0] wb_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] operand_a;
   logic [WIDTH-1:0] operand_b;
   logic [4:0]       alu_control;
   logic [SW-1:0]    shift_amount;
   logic [WIDTH-1:0] out_rs2_value;
   logic [RA-1:0]    out_rd_addr;
   logic             out_is_load;
   logic [31:0]      stall_count;

   modport master (
      output flush, in_valid, in_rs1_addr, in_rs2_addr, in_rd_addr,
             in_rs1_data, in_rs2_data, in_imm, in_pc, in_use_imm, in_use_pc,
             in_alu_control, in_is_load, mem_wr_en, mem_rd_addr, mem_data,
             wb_wr_en, wb_rd_addr, wb_data, out_ready,
      input  in_ready, out_valid, operand_a, operand_b, alu_control,
             shift_amount, out_rs2_value, out_rd_addr, out_is_load, stall_count
   );

   modport slave (
      input  flush, in_valid, in_rs1_addr, in_rs2_addr, in_rd_addr,
             in_rs1_data, in_rs2_data, in_imm, in_pc, in_use_imm, in_use_pc,
             in_alu_control, in_is_load, mem_wr_en, mem_rd_addr, mem_data,
             wb_wr_en, wb_rd_addr, wb_data, out_ready,
      output in_ready, out_valid, operand_a, operand_b, alu_control,
             shift_amount, out_rs2_value, out_rd_addr, out_is_load, stall_count
   );
endinterface

// File: rtl/alu_operand_stage.sv
// ID/EX register stage: captures decoded instructions, forwards from EX/MEM
// and MEM/WB into the ALU operands, and inserts one bubble on load-use.
module alu_operand_stage #(
   parameter int WIDTH = 32,
   parameter int RA    = 5
) (
   input logic               clk,
   input logic               rst,
   alu_operand_stage_if.slave bus
);
   localparam int SW = $clog2(WIDTH);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [RA-1:0]    rs1_addr_q, rs1_addr_d;
   logic [RA-1:0]    rs2_addr_q, rs2_addr_d;
   logic [RA-1:0]    rd_addr_q, rd_addr_d;
   logic [WIDTH-1:0] rs1_val_q, rs1_val_d;
   logic [WIDTH-1:0] rs2_val_q, rs2_val_d;
   logic [WIDTH-1:0] imm_q, imm_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic             use_imm_q, use_imm_d;
   logic             use_pc_q, use_pc_d;
   logic             is_load_q, is_load_d;
   logic [4:0]       alu_ctl_q, alu_ctl_d;
   logic [31:0]      stall_count_q, stall_count_d;

   logic             advance;
   logic             hz;
   logic [WIDTH-1:0] fwd_rs1;
   logic [WIDTH-1:0] fwd_rs2;
   logic [WIDTH-1:0] op_b;

   // EX/MEM wins over MEM/WB because it carries the younger write.
   function automatic logic [WIDTH-1:0] forward(
      input logic [RA-1:0]    addr,
      input logic [WIDTH-1:0] held,
      input logic             m_en,
      input logic [RA-1:0]    m_rd,
      input logic [WIDTH-1:0] m_data,
      input logic             w_en,
      input logic [RA-1:0]    w_rd,
      input logic [WIDTH-1:0] w_data
   );
      if (addr == '0)                 return '0;
      else if (m_en && m_rd == addr)  return m_data;
      else if (w_en && w_rd == addr)  return w_data;
      else                            return held;
   endfunction

   assign advance = (state_q == EMPTY) || bus.out_ready;
   assign hz = bus.in_valid && (state_q == FULL) && is_load_q && (rd_addr_q != '0) &&
               ((rd_addr_q == bus.in_rs1_addr) ||
                ((rd_addr_q == bus.in_rs2_addr) && !bus.in_use_imm));
   assign bus.in_ready = bus.flush || (advance && !hz);

   always_comb begin
      state_d       = state_q;
      rs1_addr_d    = rs1_addr_q;
      rs2_addr_d    = rs2_addr_q;
      rd_addr_d     = rd_addr_q;
      rs1_val_d     = rs1_val_q;
      rs2_val_d     = rs2_val_q;
      imm_d         = imm_q;
      pc_d          = pc_q;
      use_imm_d     = use_imm_q;
      use_pc_d      = use_pc_q;
      is_load_d     = is_load_q;
      alu_ctl_d     = alu_ctl_q;
      stall_count_d = stall_count_q;

      if (bus.flush) begin
         state_d = EMPTY;
      end else if (advance && hz) begin
         state_d = EMPTY;
         if (stall_count_q != 32'hFFFF_FFFF) begin
            stall_count_d = stall_count_q + 32'd1;
         end
      end else if (advance) begin
         if (bus.in_valid) begin
            state_d    = FULL;
            rs1_addr_d = bus.in_rs1_addr;
            rs2_addr_d = bus.in_rs2_addr;
            rd_addr_d  = bus.in_rd_addr;
            // Same-cycle register-file write would otherwise be missed.
            rs1_val_d  = (bus.wb_wr_en && bus.wb_rd_addr != '0 && bus.wb_rd_addr == bus.in_rs1_addr)
                         ? bus.wb_data : bus.in_rs1_data;
            rs2_val_d  = (bus.wb_wr_en && bus.wb_rd_addr != '0 && bus.wb_rd_addr == bus.in_rs2_addr)
                         ? bus.wb_data : bus.in_rs2_data;
            imm_d      = bus.in_imm;
            pc_d       = bus.in_pc;
            use_imm_d  = bus.in_use_imm;
            use_pc_d   = bus.in_use_pc;
            is_load_d  = bus.in_is_load;
            alu_ctl_d  = bus.in_alu_control;
         end else begin
            state_d = EMPTY;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= EMPTY;
         rs1_addr_q    <= '0;
         rs2_addr_q    <= '0;
         rd_addr_q     <= '0;
         rs1_val_q     <= '0;
         rs2_val_q     <= '0;
         imm_q         <= '0;
         pc_q          <= '0;
         use_imm_q     <= 1'b0;
         use_pc_q      <= 1'b0;
         is_load_q     <= 1'b0;
         alu_ctl_q     <= '0;
         stall_count_q <= '0;
      end else begin
         state_q       <= state_d;
         rs1_addr_q    <= rs1_addr_d;
         rs2_addr_q    <= rs2_addr_d;
         rd_addr_q     <= rd_addr_d;
         rs1_val_q     <= rs1_val_d;
         rs2_val_q     <= rs2_val_d;
         imm_q         <= imm_d;
         pc_q          <= pc_d;
         use_imm_q     <= use_imm_d;
         use_pc_q      <= use_pc_d;
         is_load_q     <= is_load_d;
         alu_ctl_q     <= alu_ctl_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign fwd_rs1 = forward(rs1_addr_q, rs1_val_q, bus.mem_wr_en, bus.mem_rd_addr, bus.mem_data,
                            bus.wb_wr_en, bus.wb_rd_addr, bus.wb_data);
   assign fwd_rs2 = forward(rs2_addr_q, rs2_val_q, bus.mem_wr_en, bus.mem_rd_addr, bus.mem_data,
                            bus.wb_wr_en, bus.wb_rd_addr, bus.wb_data);
   assign op_b    = use_imm_q ? imm_q : fwd_rs2;

   assign bus.out_valid     = (state_q == FULL);
   assign bus.operand_a     = use_pc_q ? pc_q : fwd_rs1;
   assign bus.operand_b     = op_b;
   assign bus.shift_amount  = op_b[SW-1:0];
   assign bus.out_rs2_value = fwd_rs2;
   assign bus.alu_control   = alu_ctl_q;
   assign bus.out_rd_addr   = rd_addr_q;
   assign bus.out_is_load   = is_load_q;
   assign bus.stall_count   = stall_count_q;
endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed plus randomized checks of alu_operand_stage against a slot-level
// behavioural model of the ID/EX register.
module tb_alu_operand_stage;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   alu_operand_stage_if #(.WIDTH(32), .RA(5)) bus ();
   alu_operand_stage #(.WIDTH(32), .RA(5)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      logic        valid;
      logic [4:0]  rs1, rs2, rd, ctl;
      logic [31:0] v1, v2, imm, pc;
      logic        use_imm, use_pc, is_load;
   } slot_t;

   slot_t       m;
   logic [31:0] m_stall;
   int          tests = 0;
   int          fails = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Value a source register holds as seen by the ALU this cycle.
   function automatic logic [31:0] model_value(input logic [4:0] r, input logic [31:0] held);
      logic [31:0] v;
      v = held;
      if (bus.wb_wr_en && bus.wb_rd_addr == r)   v = bus.wb_data;
      if (bus.mem_wr_en && bus.mem_rd_addr == r) v = bus.mem_data;
      if (r == 5'd0) v = 32'd0;
      return v;
   endfunction

   // The offered consumer needs the result of the load currently held.
   function automatic bit model_load_use();
      bit reads_rd;
      reads_rd = (bus.in_rs1_addr == m.rd) || (!bus.in_use_imm && bus.in_rs2_addr == m.rd);
      return bus.in_valid && m.valid && m.is_load && (m.rd != 5'd0) && reads_rd;
   endfunction

   task automatic check_model();
      logic [31:0] a, b, s2;
      bit          can_move;
      s2 = model_value(m.rs2, m.v2);
      a  = m.use_pc ? m.pc : model_value(m.rs1, m.v1);
      b  = m.use_imm ? m.imm : s2;
      can_move = !m.valid || bus.out_ready;
      check("out_valid", 32'(bus.out_valid), 32'(m.valid));
      check("in_ready", 32'(bus.in_ready), 32'(bus.flush || (can_move && !model_load_use())));
      check("operand_a", bus.operand_a, a);
      check("operand_b", bus.operand_b, b);
      check("shift_amount", 32'(bus.shift_amount), b % 32);
      check("rs2_value", bus.out_rs2_value, s2);
      check("alu_control", 32'(bus.alu_control), 32'(m.ctl));
      check("rd_addr", 32'(bus.out_rd_addr), 32'(m.rd));
      check("is_load", 32'(bus.out_is_load), 32'(m.is_load));
      check("stall_count", bus.stall_count, m_stall);
   endtask

   task automatic model_clock();
      slot_t n;
      n = m;
      if (rst) begin
         n = '{default: '0};
         m_stall = 32'd0;
      end else if (bus.flush) begin
         n.valid = 1'b0;
      end else if (!m.valid || bus.out_ready) begin
         if (model_load_use()) begin
            n.valid = 1'b0;
            if (m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
         end else if (bus.in_valid) begin
            n.valid   = 1'b1;
            n.rs1     = bus.in_rs1_addr;
            n.rs2     = bus.in_rs2_addr;
            n.rd      = bus.in_rd_addr;
            n.v1      = (bus.wb_wr_en && bus.wb_rd_addr != 0 && bus.wb_rd_addr == bus.in_rs1_addr)
                        ? bus.wb_data : bus.in_rs1_data;
            n.v2      = (bus.wb_wr_en && bus.wb_rd_addr != 0 && bus.wb_rd_addr == bus.in_rs2_addr)
                        ? bus.wb_data : bus.in_rs2_data;
            n.imm     = bus.in_imm;
            n.pc      = bus.in_pc;
            n.use_imm = bus.in_use_imm;
            n.use_pc  = bus.in_use_pc;
            n.is_load = bus.in_is_load;
            n.ctl     = bus.in_alu_control;
         end else begin
            n.valid = 1'b0;
         end
      end
      m = n;
   endtask

   task automatic step();
      @(negedge clk);
      check_model();
      model_clock();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.flush = 0; bus.in_valid = 0; bus.out_ready = 1;
      bus.in_rs1_addr = 0; bus.in_rs2_addr = 0; bus.in_rd_addr = 0;
      bus.in_rs1_data = 0; bus.in_rs2_data = 0; bus.in_imm = 0; bus.in_pc = 0;
      bus.in_use_imm = 0; bus.in_use_pc = 0; bus.in_alu_control = 0; bus.in_is_load = 0;
      bus.mem_wr_en = 0; bus.mem_rd_addr = 0; bus.mem_data = 0;
      bus.wb_wr_en = 0; bus.wb_rd_addr = 0; bus.wb_data = 0;
   endtask

   task automatic offer(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic [31:0] d1, input logic [31:0] d2, input logic ld);
      bus.in_valid = 1; bus.in_rs1_addr = rs1; bus.in_rs2_addr = rs2; bus.in_rd_addr = rd;
      bus.in_rs1_data = d1; bus.in_rs2_data = d2; bus.in_imm = 32'h21; bus.in_pc = 32'h400;
      bus.in_use_imm = 0; bus.in_use_pc = 0; bus.in_alu_control = 5'b00000; bus.in_is_load = ld;
   endtask

   initial begin
      idle();
      rst = 1;
      repeat (2) @(posedge clk);
      #1;
      m = '{default: '0};
      m_stall = 0;
      rst = 0;
      #1;
      check("rst_valid", 32'(bus.out_valid), 0);
      check("rst_a", bus.operand_a, 0);
      check("rst_b", bus.operand_b, 0);
      check("rst_rs2", bus.out_rs2_value, 0);
      check("rst_ctl", 32'(bus.alu_control), 0);
      check("rst_shamt", 32'(bus.shift_amount), 0);
      check("rst_rd", 32'(bus.out_rd_addr), 0);
      check("rst_load", 32'(bus.out_is_load), 0);
      check("rst_stall", bus.stall_count, 0);
      check("rst_ready", 32'(bus.in_ready), 1);

      // Basic flow
      offer(5'd3, 5'd4, 5'd1, 32'd10, 32'd7, 0);
      step();
      check("basic_valid", 32'(bus.out_valid), 1);
      check("basic_a", bus.operand_a, 32'd10);
      check("basic_b", bus.operand_b, 32'd7);
      check("basic_ready", 32'(bus.in_ready), 1);

      // Forwarding priority
      offer(5'd5, 5'd0, 5'd2, 32'h11, 32'h0, 0);
      step();
      bus.in_valid = 0; bus.out_ready = 0;
      bus.mem_wr_en = 1; bus.mem_rd_addr = 5'd5; bus.mem_data = 32'hAA;
      bus.wb_wr_en = 1; bus.wb_rd_addr = 5'd5; bus.wb_data = 32'hBB;
      #1 check("fwd_mem", bus.operand_a, 32'hAA);
      bus.mem_wr_en = 0;
      #1 check("fwd_wb", bus.operand_a, 32'hBB);
      step();
      bus.out_ready = 1;
      offer(5'd0, 5'd0, 5'd2, 32'h77, 32'h0, 0);
      bus.mem_wr_en = 1; bus.mem_rd_addr = 5'd0; bus.wb_rd_addr = 5'd0;
      step();
      bus.in_valid = 0; bus.out_ready = 0;
      #1 check("fwd_zero", bus.operand_a, 32'd0);
      step();

      // Load-use bubble
      idle();
      offer(5'd1, 5'd2, 5'd6, 32'h0, 32'h0, 1);
      step();
      offer(5'd1, 5'd6, 5'd7, 32'h9, 32'h123, 0);
      #1 check("lu_ready", 32'(bus.in_ready), 0);
      step();
      check("lu_bubble", 32'(bus.out_valid), 0);
      check("lu_stall", bus.stall_count, 32'd1);
      check("lu_ready2", 32'(bus.in_ready), 1);
      step();
      bus.in_valid = 0;
      bus.wb_wr_en = 1; bus.wb_rd_addr = 5'd6; bus.wb_data = 32'h66;
      #1 check("lu_valid", 32'(bus.out_valid), 1);
      check("lu_b", bus.operand_b, 32'h66);
      step();

      // Backpressure with a pending hazard
      idle();
      offer(5'd1, 5'd2, 5'd9, 32'd5, 32'd6, 1);
      step();
      offer(5'd9, 5'd3, 5'd10, 32'd1, 32'd2, 0);
      bus.out_ready = 0;
      for (int k = 0; k < 3; k++) begin
         #1;
         check("bp_ready", 32'(bus.in_ready), 0);
         check("bp_valid", 32'(bus.out_valid), 1);
         check("bp_a", bus.operand_a, 32'd5);
         check("bp_stall", bus.stall_count, 32'd1);
         step();
      end

      // Flush while full with an offer
      bus.flush = 1;
      #1 check("fl_ready", 32'(bus.in_ready), 1);
      step();
      bus.flush = 0; bus.in_valid = 0;
      #1 check("fl_valid", 32'(bus.out_valid), 0);

      // Reset during a load-use stall
      idle();
      offer(5'd1, 5'd2, 5'd6, 32'h3, 32'h4, 1);
      step();
      offer(5'd6, 5'd0, 5'd8, 32'h0, 32'h0, 0);
      rst = 1;
      step();
      rst = 0;
      idle();
      #1;
      check("rs_valid", 32'(bus.out_valid), 0);
      check("rs_stall", bus.stall_count, 0);
      check("rs_a", bus.operand_a, 0);
      check("rs_load", 32'(bus.out_is_load), 0);

      // Capture write-through
      offer(5'd2, 5'd0, 5'd3, 32'h0, 32'h0, 0);
      bus.wb_wr_en = 1; bus.wb_rd_addr = 5'd2; bus.wb_data = 32'h55;
      step();
      bus.wb_wr_en = 0; bus.in_valid = 0; bus.out_ready = 0;
      #1 check("wt_a", bus.operand_a, 32'h55);
      step();

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         rst                = ($urandom_range(0, 99) == 0);
         bus.flush          = ($urandom_range(0, 19) == 0);
         bus.in_valid       = ($urandom_range(0, 3) != 0);
         bus.out_ready      = ($urandom_range(0, 3) != 0);
         bus.in_rs1_addr    = 5'($urandom_range(0, 7));
         bus.in_rs2_addr    = 5'($urandom_range(0, 7));
         bus.in_rd_addr     = 5'($urandom_range(0, 7));
         bus.in_rs1_data    = $urandom;
         bus.in_rs2_data    = $urandom;
         bus.in_imm         = $urandom;
         bus.in_pc          = $urandom;
         bus.in_use_imm     = ($urandom_range(0, 2) == 0);
         bus.in_use_pc      = ($urandom_range(0, 3) == 0);
         bus.in_alu_control = 5'($urandom_range(0, 31));
         bus.in_is_load     = ($urandom_range(0, 2) == 0);
         bus.mem_wr_en      = ($urandom_range(0, 1) == 0);
         bus.mem_rd_addr    = 5'($urandom_range(0, 7));
         bus.mem_data       = $urandom;
         bus.wb_wr_en       = ($urandom_range(0, 1) == 0);
         bus.wb_rd_addr     = 5'($urandom_range(0, 7));
         bus.wb_data        = $urandom;
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
